// File: rtl/sram_like_bridge.sv
// Bridges the core's inst/data SRAM ports onto one sram-like bus.
// Data port goes first; stallreq holds the pipeline until both finish.
module sram_like_bridge #(
  parameter int WAIT_MAX = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] WM1  = CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE
  } state_t;

  state_t        r_state;
  logic          r_d_done;
  logic          r_i_done;
  logic [CW-1:0] r_wcnt;
  logic          r_bus_req;
  logic          r_bus_wr;
  logic [1:0]    r_bus_size;
  logic [3:0]    r_bus_wstrb;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic          r_bus_err;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;

  logic       w_d_pend;
  logic       w_i_pend;
  logic       w_in_req;
  logic       w_in_wait;
  logic       w_adv;
  logic [1:0] w_dsize;

  assign w_d_pend  = data_sram_en & ~r_d_done;
  assign w_i_pend  = inst_sram_en & ~r_i_done;
  assign w_in_req  = (r_state == D_REQ) | (r_state == I_REQ);
  assign w_in_wait = (r_state == D_WAIT) | (r_state == I_WAIT);
  assign w_adv     = (w_in_req & bus_addr_ok)
                   | (w_in_wait & bus_data_ok);

  assign stallreq = (r_state != DONE) & (w_d_pend | w_i_pend);

  always_comb begin
    w_dsize = 2'd2;
    case (data_sram_wen)
      4'b0011, 4'b1100: w_dsize = 2'd1;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: w_dsize = 2'd0;
      default:          w_dsize = 2'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_d_done    <= 1'b0;
      r_i_done    <= 1'b0;
      r_wcnt      <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd0;
      r_bus_wstrb <= 4'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_err   <= 1'b0;
      r_i_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      // Timeout only flags; the transaction is never abandoned.
      if ((w_in_req | w_in_wait) & ~w_adv) begin
        if (r_wcnt != WMAX) r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt >= WM1) r_bus_err <= 1'b1;
      end else begin
        r_wcnt <= '0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_d_pend) begin
            r_state     <= D_REQ;
            r_bus_req   <= 1'b1;
            r_bus_wr    <= |data_sram_wen;
            r_bus_size  <= w_dsize;
            r_bus_wstrb <= data_sram_wen;
            r_bus_addr  <= data_sram_addr;
            r_bus_wdata <= data_sram_wdata;
          end else if (w_i_pend) begin
            r_state     <= I_REQ;
            r_bus_req   <= 1'b1;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd2;
            r_bus_wstrb <= 4'd0;
            r_bus_addr  <= inst_sram_addr;
            r_bus_wdata <= 32'd0;
          end
        end
        D_REQ: begin
          if (bus_addr_ok) begin
            r_state   <= D_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        D_WAIT: begin
          if (bus_data_ok) begin
            r_d_done <= 1'b1;
            if (!r_bus_wr) r_d_rdata <= bus_rdata;
            if (w_i_pend) begin
              r_state     <= I_REQ;
              r_bus_req   <= 1'b1;
              r_bus_wr    <= 1'b0;
              r_bus_size  <= 2'd2;
              r_bus_wstrb <= 4'd0;
              r_bus_addr  <= inst_sram_addr;
              r_bus_wdata <= 32'd0;
            end else begin
              r_state <= DONE;
            end
          end
        end
        I_REQ: begin
          if (bus_addr_ok) begin
            r_state   <= I_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        I_WAIT: begin
          if (bus_data_ok) begin
            r_i_rdata <= bus_rdata;
            r_i_done  <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_d_done <= 1'b0;
          r_i_done <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req         = r_bus_req;
  assign bus_wr          = r_bus_wr;
  assign bus_size        = r_bus_size;
  assign bus_wstrb       = r_bus_wstrb;
  assign bus_addr        = r_bus_addr;
  assign bus_wdata       = r_bus_wdata;
  assign bus_err         = r_bus_err;
  assign inst_sram_rdata = r_i_rdata;
  assign data_sram_rdata = r_d_rdata;

endmodule
